uart_tx_fifo: RTL

//   Buffered 8N1 UART transmitter sitting downstream of the memory stage: accepts byte

---
 rtl/uart_tx_fifo.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte writes land in a small FIFO and are
// serialised LSB first on uart_tx. Frames are sent back to back while bytes
// remain queued.
module uart_tx_fifo #(
   parameter int DIVISOR = 868,
   parameter int DEPTH   = 16,
   parameter int AW      = 4
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          wr_enablen,
   input  logic [7:0]    wr_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level,
   output logic          busy,
   output logic          overflow,
   output logic          uart_tx
);

   localparam int              DW       = $clog2(DIVISOR);
   localparam logic [DW-1:0]   DIV_LAST = DW'(DIVISOR - 1);
   localparam logic [DW-1:0]   DIV_ONE  = DW'(1);
   localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
   localparam logic [AW:0]     LVL_ONE  = (AW+1)'(1);
   localparam logic [AW:0]     LVL_FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          r_overflow;

   state_t        r_state;
   logic [DW-1:0] r_div;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_tx;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_div_done;
   state_t        w_state_next;
   logic [DW-1:0] w_div_next;
   logic [2:0]    w_bit_next;
   logic [7:0]    w_shift_next;
   logic          w_tx_next;

   // Full is taken from the registered level, so a write arriving while full
   // is dropped even when the transmitter pops at the same edge.
   assign w_full  = (r_level == LVL_FULL);
   assign w_empty = (r_level == '0);
   assign w_push  = ~wr_enablen & ~w_full;

   // FIFO storage: written on push, no reset needed for the data itself.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   // FIFO pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + LVL_ONE;
         end else if (!w_push && w_pop) begin
            r_level <= r_level - LVL_ONE;
         end
         if (!wr_enablen && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Transmitter state register; the line output is registered so it never glitches.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_div   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_next;
         r_div   <= w_div_next;
         r_bit   <= w_bit_next;
         r_shift <= w_shift_next;
         r_tx    <= w_tx_next;
      end
   end

   assign w_div_done = (r_div == DIV_LAST);

   // Next-state logic: the divider restarts on every state change, and the
   // line level is derived from the state being entered.
   always_comb begin
      w_state_next = r_state;
      w_div_next   = r_div + DIV_ONE;
      w_bit_next   = r_bit;
      w_shift_next = r_shift;
      w_pop        = 1'b0;
      w_tx_next    = 1'b1;

      case (r_state)
         IDLE: begin
            w_div_next = '0;
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_shift_next = r_mem[r_rd_ptr];
               w_state_next = START;
            end
         end
         START: begin
            if (w_div_done) begin
               w_div_next   = '0;
               w_bit_next   = '0;
               w_state_next = DATA;
            end
         end
         DATA: begin
            if (w_div_done) begin
               w_div_next   = '0;
               w_shift_next = {1'b0, r_shift[7:1]};
               if (r_bit == 3'd7) begin
                  w_state_next = STOP;
               end else begin
                  w_bit_next = r_bit + 3'd1;
               end
            end
         end
         STOP: begin
            if (w_div_done) begin
               w_div_next = '0;
               if (!w_empty) begin
                  // Chain straight into the next start bit, no idle gap.
                  w_pop        = 1'b1;
                  w_shift_next = r_mem[r_rd_ptr];
                  w_state_next = START;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         default: begin
            w_div_next   = '0;
            w_state_next = IDLE;
         end
      endcase

      case (w_state_next)
         START:   w_tx_next = 1'b0;
         DATA:    w_tx_next = w_shift_next[0];
         default: w_tx_next = 1'b1;
      endcase
   end

   assign full     = w_full;
   assign empty    = w_empty;
   assign level    = r_level;
   assign overflow = r_overflow;
   assign uart_tx  = r_tx;
   assign busy     = (r_state != IDLE) | ~w_empty;

endmodule
